// File: rtl/ultrasonic_presence_if.sv
// Signal bundle between the HC-SR04 ranger controller and the sensor/consumer side.
// master = controller (drives trig and results), slave = sensor echo plus result consumer.
interface ultrasonic_presence_if;
    logic        echo;
    logic        trig;
    logic        ult;
    logic [15:0] echo_us;
    logic        meas_valid;
    logic        meas_timeout;

    modport master (
        input  echo,
        output trig, ult, echo_us, meas_valid, meas_timeout
    );

    modport slave (
        output echo,
        input  trig, ult, echo_us, meas_valid, meas_timeout
    );
endinterface

// File: rtl/ultrasonic_presence.sv
// HC-SR04 driver: periodic trigger, microsecond echo timing, near/far classification and
// a CONFIRM-deep agreement filter that produces the debounced presence flag 'ult'.
module ultrasonic_presence #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60_000,
    parameter int TIMEOUT_US = 25_000,
    parameter int NEAR_CM    = 10,
    parameter int CONFIRM    = 3
) (
    input  logic                   clk,
    input  logic                   btn_reset,
    ultrasonic_presence_if.master  bus
);

    localparam int CYC_US  = CLK_HZ / 1_000_000;
    localparam int NEAR_US = NEAR_CM * 58;
    localparam int PRE_W   = (CYC_US > 1) ? $clog2(CYC_US) : 1;
    localparam int US_MAX0 = (PERIOD_US > TIMEOUT_US) ? PERIOD_US : TIMEOUT_US;
    localparam int US_MAX  = (US_MAX0 > TRIG_US) ? US_MAX0 : TRIG_US;
    localparam int US_W    = $clog2(US_MAX + 1);
    localparam int CNF_W   = $clog2(CONFIRM + 1);

    typedef enum logic [1:0] {S_WAIT, S_TRIG, S_ARM, S_MEAS} state_t;

    state_t            state, state_next;
    logic              echo_m, echo_s, echo_d;
    logic [PRE_W-1:0]  pre;
    logic [US_W-1:0]   us_cnt;
    logic              seen_low;
    logic [CNF_W-1:0]  cnt;
    logic              ult_q, trig_q, mv_q, to_q;
    logic [15:0]       us_q;

    logic              tick, wait_done, trig_done, tmo_done, rise;
    logic              res_valid, res_timeout, near;
    logic [15:0]       res_us;

    assign tick      = (pre == PRE_W'(CYC_US - 1));
    assign wait_done = tick && (us_cnt == US_W'(PERIOD_US - 1));
    assign trig_done = tick && (us_cnt == US_W'(TRIG_US - 1));
    assign tmo_done  = tick && (us_cnt == US_W'(TIMEOUT_US - 1));
    // A rise only counts once echo has been seen low inside S_ARM, so a stuck-high echo never arms.
    assign rise      = echo_s && !echo_d && seen_low;

    // Two-flop synchronizer for the asynchronous echo, plus one more stage for edge detection.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= bus.echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) state <= S_WAIT;
        else            state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_next  = state;
        res_valid   = 1'b0;
        res_timeout = 1'b0;
        res_us      = '0;
        case (state)
            S_WAIT: if (wait_done) state_next = S_TRIG;
            S_TRIG: if (trig_done) state_next = S_ARM;
            S_ARM: begin
                if (rise) begin
                    state_next = S_MEAS;
                end else if (tmo_done) begin
                    res_valid   = 1'b1;
                    res_timeout = 1'b1;
                    res_us      = 16'(TIMEOUT_US);
                    state_next  = S_WAIT;
                end
            end
            S_MEAS: begin
                if (!echo_s) begin
                    // The cycle spent detecting the rise is part of the pulse: add it back on wrap.
                    res_valid  = 1'b1;
                    res_us     = 16'(us_cnt) + {15'd0, tick};
                    state_next = S_WAIT;
                end else if (tmo_done) begin
                    res_valid   = 1'b1;
                    res_timeout = 1'b1;
                    res_us      = 16'(TIMEOUT_US);
                    state_next  = S_WAIT;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    assign near = !res_timeout && (res_us <= 16'(NEAR_US));

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            pre      <= '0;
            us_cnt   <= '0;
            seen_low <= 1'b0;
            cnt      <= '0;
            ult_q    <= 1'b0;
            trig_q   <= 1'b0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
            us_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            trig_q <= (state_next == S_TRIG);
            mv_q   <= res_valid;
            if (state_next != state) begin
                pre      <= '0;
                us_cnt   <= '0;
                seen_low <= 1'b0;
            end else begin
                pre <= tick ? '0 : pre + PRE_W'(1);
                if (tick) us_cnt <= us_cnt + US_W'(1);
                if (state == S_ARM && !echo_s) seen_low <= 1'b1;
            end
            if (res_valid) begin
                us_q <= res_us;
                to_q <= res_timeout;
                if (near == ult_q) begin
                    cnt <= '0;
                end else if (cnt == CNF_W'(CONFIRM - 1)) begin
                    ult_q <= ~ult_q;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNF_W'(1);
                end
            end
        end
    end

    assign bus.trig         = trig_q;
    assign bus.ult          = ult_q;
    assign bus.echo_us      = us_q;
    assign bus.meas_valid   = mv_q;
    assign bus.meas_timeout = to_q;

endmodule

// File: tb/tb_ultrasonic_presence.sv
// Self-checking bench for ultrasonic_presence: scripted and random echo pulses compared
// against a measurement-level model of timing, echo width and the confirm filter.
module tb_ultrasonic_presence;

    localparam int CLK_HZ     = 4_000_000;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 200;
    localparam int TIMEOUT_US = 1000;
    localparam int NEAR_CM    = 5;
    localparam int CONFIRM    = 3;
    localparam int CYC_US     = CLK_HZ / 1_000_000;
    localparam int NEAR_US    = NEAR_CM * 58;

    logic clk = 1'b0;
    logic btn_reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    bit   m_ult = 1'b0;
    int   m_cnt = 0;
    int   ref_cyc = 0;

    ultrasonic_presence_if bus ();

    ultrasonic_presence #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US), .NEAR_CM(NEAR_CM), .CONFIRM(CONFIRM)
    ) dut (
        .clk(clk),
        .btn_reset(btn_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Measurement-level reference: h = raw echo high cycles, negative = no echo.
    task automatic model_meas(input int h, output int e_us, output bit e_to);
        bit nr;
        if (h < 0 || h > TIMEOUT_US * CYC_US) begin
            e_us = TIMEOUT_US;
            e_to = 1'b1;
        end else begin
            e_us = h / CYC_US;
            e_to = 1'b0;
        end
        nr = !e_to && (e_us <= NEAR_US);
        if (nr == m_ult) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == CONFIRM) begin
                m_ult = !m_ult;
                m_cnt = 0;
            end
        end
    endtask

    task automatic wait_trig_window(output int r, output bit ok);
        int stray = 0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.meas_valid) stray++;
            if (bus.trig) ok = 1'b1;
        end
        check("trig_seen", ok, 1);
        r = cyc;
        if (ok) begin
            check("trig_gap", r - ref_cyc, PERIOD_US * CYC_US);
            check("stray_mv", stray, 0);
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (!bus.trig) ok = 1'b1;
            end
            check("trig_width", cyc - r, TRIG_US * CYC_US);
        end
    endtask

    // One full measurement cycle; stuck raises echo after the trigger and leaves it high.
    task automatic measure(input int h, input bit stuck);
        int  r, f, s, base, lat, e_us;
        bit  ok, e_to;
        if (bus.echo == 1'b0) begin
            repeat (10) @(negedge clk);
            bus.echo = 1'b1;
            repeat (40) @(negedge clk);
            bus.echo = 1'b0;
        end
        wait_trig_window(r, ok);
        if (!ok) return;
        f = cyc;
        s = f;
        if (stuck) begin
            bus.echo = 1'b1;
            s = cyc;
        end else if (h >= 0) begin
            repeat ($urandom_range(1, 100)) @(negedge clk);
            bus.echo = 1'b1;
            repeat (h) @(negedge clk);
            bus.echo = 1'b0;
            s = cyc;
        end
        if (stuck)       begin base = s; lat = TIMEOUT_US * CYC_US + 3; end
        else if (h < 0)  begin base = f; lat = TIMEOUT_US * CYC_US;     end
        else             begin base = s; lat = 3;                       end
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            if (bus.meas_valid) ok = 1'b1;
        end
        check("mv_seen", ok, 1);
        if (!ok) return;
        check("mv_latency", cyc - base, lat);
        model_meas(stuck ? -1 : h, e_us, e_to);
        check("echo_us", bus.echo_us, e_us);
        check("meas_timeout", bus.meas_timeout, e_to);
        check("ult", bus.ult, m_ult);
        check("trig_vs_mv", bus.trig, 0);
        ref_cyc = cyc;
        @(negedge clk);
        check("mv_pulse", bus.meas_valid, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r, h;
        bit  ok;
        btn_reset = 1'b0;
        bus.echo  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_trig", bus.trig, 0);
        check("rst_ult", bus.ult, 0);
        check("rst_echo_us", bus.echo_us, 0);
        check("rst_mv", bus.meas_valid, 0);
        check("rst_to", bus.meas_timeout, 0);
        btn_reset = 1'b1;
        ref_cyc = cyc;

        // No echo: periodic timeouts.
        measure(-1, 0);
        measure(-1, 0);
        // Far echo of 580 us.
        measure(2320, 0);
        // Three near echoes raise ult; exact threshold still near.
        repeat (3) measure(800, 0);
        measure(1160, 0);
        // Far runs broken by a near result, then a full far run clears ult.
        measure(1164, 0);
        measure(-1, 0);
        measure(1160, 0);
        measure(2000, 0);
        measure(-1, 0);
        measure(1200, 0);

        // Randomized measurements, biased toward the near/far boundary.
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 4))
                0:       h = -1;
                1, 2:    h = $urandom_range(1100, 1220);
                default: h = $urandom_range(1, 2400);
            endcase
            measure(h, 0);
        end

        // Stuck-high echo: timeout in S_MEAS, then timeout in S_ARM.
        measure(0, 1);
        measure(-1, 0);
        bus.echo = 1'b0;

        // Reset in the middle of a measurement while ult is high.
        for (int i = 0; i < 4 && !m_ult; i++) measure(800, 0);
        check("pre_reset_ult", bus.ult, 1);
        repeat (10) @(negedge clk);
        wait_trig_window(r, ok);
        repeat (20) @(negedge clk);
        bus.echo = 1'b1;
        repeat (100) @(negedge clk);
        btn_reset = 1'b0;
        #1;
        check("mid_rst_trig", bus.trig, 0);
        check("mid_rst_ult", bus.ult, 0);
        check("mid_rst_mv", bus.meas_valid, 0);
        check("mid_rst_echo_us", bus.echo_us, 0);
        m_ult = 1'b0;
        m_cnt = 0;
        bus.echo = 1'b0;
        repeat (5) @(negedge clk);
        btn_reset = 1'b1;
        ref_cyc = cyc;
        measure(800, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
